// File: rtl/dev_arb_pkg.sv
// ---------------------------------------------------------------------------
// dev_arb_pkg
// Shared definitions for device_event_arbiter and its round-robin picker:
//   - N_DEV_DEF : default number of requesting devices
//   - CNT_W     : width of the active-device count reported to the monitor
//   - PTR_W     : width of the round-robin pointer (covers up to 16 devices)
//   - state_t   : FSM state encoding (IDLE / ISSUE / SETTLE)
//   - onehot_to_idx : converts a one-hot winner vector to a device index
// ---------------------------------------------------------------------------
package dev_arb_pkg;

   localparam int N_DEV_DEF = 8;
   localparam int CNT_W     = 8;
   localparam int PTR_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [15:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches the pending vector starting
// at index i_ptr and wrapping around; the first pending device found wins.
// Ports:
//   i_pend   [N_DEV-1:0]  devices with an outstanding event
//   i_ptr    [PTR_W-1:0]  index where the search starts
//   o_winner [N_DEV-1:0]  one-hot winner (all zero when nothing pending)
//   o_valid               at least one device is pending
// ---------------------------------------------------------------------------
module rr_picker
   import dev_arb_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEF
) (
   input  logic [N_DEV-1:0] i_pend,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N_DEV-1:0] o_winner,
   output logic             o_valid
);

   // NOTE: every variable driven in always_comb gets a default at the top so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      // First pass: devices at or above the pointer.
      for (int i = 0; i < N_DEV; i++) begin
         if (!o_valid && i_pend[i] && (i >= int'(i_ptr))) begin
            o_winner[i] = 1'b1;
            o_valid     = 1'b1;
         end
      end
      // Second pass: wrap around to devices below the pointer.
      for (int i = 0; i < N_DEV; i++) begin
         if (!o_valid && i_pend[i] && (i < int'(i_ptr))) begin
            o_winner[i] = 1'b1;
            o_valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/device_event_arbiter.sv
// ---------------------------------------------------------------------------
// device_event_arbiter
// Collects per-device join/leave requests into pending bitmaps, services one
// pending event every three cycles (IDLE -> ISSUE -> SETTLE) in round-robin
// order, keeps the registered active bitmap and expected count, and flags any
// disagreement with the count reported back by the downstream monitor.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   join_req  [N_DEV-1:0]       level request to register a device
//   leave_req [N_DEV-1:0]       level request to deregister a device
//   mon_count [7:0]             active count returned by the monitor
//   change                      monitor update strobe (ISSUE only)
//   on_off                      1 = increment, 0 = decrement
//   grant     [N_DEV-1:0]       one-hot device being serviced
//   active    [N_DEV-1:0]       registered active-device bitmap
//   busy                        FSM not idle or an event pending
//   sync_err                    sticky monitor/expected count mismatch
//   stat_events [15:0]          saturating ISSUE-cycle counter, present only
//                               when DEV_ARB_STATS_EN is defined
// ---------------------------------------------------------------------------
module device_event_arbiter
   import dev_arb_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] join_req,
   input  logic [N_DEV-1:0] leave_req,
   input  logic [CNT_W-1:0] mon_count,
   output logic             change,
   output logic             on_off,
   output logic [N_DEV-1:0] grant,
   output logic [N_DEV-1:0] active,
   output logic             busy,
   output logic             sync_err
`ifdef DEV_ARB_STATS_EN
   ,output logic [15:0]     stat_events
`endif
);

   state_t           r_state;
   state_t           w_state_next;
   logic [N_DEV-1:0] r_active;
   logic [N_DEV-1:0] r_pend_join;
   logic [N_DEV-1:0] r_pend_leave;
   logic [N_DEV-1:0] r_win;
   logic             r_dir;
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_exp_count;
   logic             r_sync_err;

   logic [N_DEV-1:0] w_pend;
   logic [N_DEV-1:0] w_pick;
   logic             w_pick_valid;
   logic [PTR_W-1:0] w_pick_idx;
   logic             w_fire;
   logic [N_DEV-1:0] w_act_post;
   logic [N_DEV-1:0] w_pj_post;
   logic [N_DEV-1:0] w_pl_post;
   logic [N_DEV-1:0] w_pj_next;
   logic [N_DEV-1:0] w_pl_next;

   assign w_pend     = r_pend_join | r_pend_leave;
   assign w_pick_idx = onehot_to_idx(16'(w_pick));

   rr_picker #(.N_DEV(N_DEV)) u_rr_picker (
      .i_pend   (w_pend),
      .i_ptr    (r_ptr),
      .o_winner (w_pick),
      .o_valid  (w_pick_valid)
   );

   // The winner is latched in IDLE; a leave arriving on that same edge may
   // cancel its pending join, so ISSUE only fires if the event still exists.
   assign w_fire = (r_state == ST_ISSUE) &&
                   (|(r_win & (r_dir ? r_pend_join : r_pend_leave)));

   // State as it will be after this cycle's ISSUE update; new requests are
   // judged against this view.
   always_comb begin
      w_act_post = r_active;
      w_pj_post  = r_pend_join;
      w_pl_post  = r_pend_leave;
      if (w_fire) begin
         w_act_post = r_dir ? (r_active | r_win) : (r_active & ~r_win);
         w_pj_post  = r_pend_join  & ~r_win;
         w_pl_post  = r_pend_leave & ~r_win;
      end
   end

   // Request filtering: at most one pending event per device; a leave
   // against a pending join simply cancels it.
   always_comb begin
      w_pj_next = w_pj_post;
      w_pl_next = w_pl_post;
      for (int i = 0; i < N_DEV; i++) begin
         if (join_req[i] && !leave_req[i]) begin
            if (!w_act_post[i] && !w_pj_post[i]) w_pj_next[i] = 1'b1;
         end else if (leave_req[i] && !join_req[i]) begin
            if (w_pj_post[i])       w_pj_next[i] = 1'b0;
            else if (w_act_post[i]) w_pl_next[i] = 1'b1;
         end
      end
   end

   // ---------------- FSM: state register ----------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_pick_valid) w_state_next = ST_ISSUE;
         ST_ISSUE:  w_state_next = ST_SETTLE;
         ST_SETTLE: w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      change = 1'b0;
      on_off = 1'b0;
      grant  = '0;
      if (w_fire) begin
         change = 1'b1;
         on_off = r_dir;
         grant  = r_win;
      end
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active     <= '0;
         r_pend_join  <= '0;
         r_pend_leave <= '0;
         r_win        <= '0;
         r_dir        <= 1'b0;
         r_ptr        <= '0;
         r_exp_count  <= '0;
         r_sync_err   <= 1'b0;
      end else begin
         r_active     <= w_act_post;
         r_pend_join  <= w_pj_next;
         r_pend_leave <= w_pl_next;
         if (w_fire) begin
            r_exp_count <= r_dir ? (r_exp_count + CNT_W'(1))
                                 : (r_exp_count - CNT_W'(1));
         end
         if ((r_state == ST_IDLE) && w_pick_valid) begin
            r_win <= w_pick;
            r_dir <= |(w_pick & r_pend_join);
            r_ptr <= (w_pick_idx == PTR_W'(N_DEV - 1)) ? '0
                                                       : (w_pick_idx + PTR_W'(1));
         end
         if ((r_state == ST_SETTLE) && (mon_count != r_exp_count)) begin
            r_sync_err <= 1'b1;
         end
      end
   end

   assign active   = r_active;
   assign sync_err = r_sync_err;
   assign busy     = (r_state != ST_IDLE) || (|w_pend);

`ifdef DEV_ARB_STATS_EN
   logic [15:0] r_stat_events;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_events <= '0;
      end else if ((r_state == ST_ISSUE) && (r_stat_events != 16'hFFFF)) begin
         r_stat_events <= r_stat_events + 16'd1;
      end
   end

   assign stat_events = r_stat_events;
`endif

endmodule

// File: tb/tb_device_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_device_event_arbiter
// Self-checking bench for device_event_arbiter (N_DEV = 8). Directed
// scenarios plus a randomized run compared cycle by cycle against a
// behavioural model of pending events, active devices and service slots.
// ---------------------------------------------------------------------------
module tb_device_event_arbiter;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] join_req;
   logic [N-1:0] leave_req;
   logic [7:0]   mon_count;
   logic         change;
   logic         on_off;
   logic [N-1:0] grant;
   logic [N-1:0] active;
   logic         busy;
   logic         sync_err;

   always #5 clk = ~clk;

   device_event_arbiter #(.N_DEV(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .join_req  (join_req),
      .leave_req (leave_req),
      .mon_count (mon_count),
      .change    (change),
      .on_off    (on_off),
      .grant     (grant),
      .active    (active),
      .busy      (busy),
      .sync_err  (sync_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- Reference model ----------------
   // m_kind: 0 = nothing pending, 1 = join pending, 2 = leave pending.
   // m_phase: 0 = waiting for work, 1 = servicing slot, 2 = settle slot.
   bit m_active [N];
   int m_kind   [N];
   int m_phase, m_win, m_ptr, m_cnt;
   bit m_dir, m_err;
   bit bad_mon;

   function automatic bit m_fire();
      return (m_phase == 1) && (m_kind[m_win] == (m_dir ? 1 : 2));
   endfunction

   function automatic logic [N-1:0] m_active_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_active[i];
      return v;
   endfunction

   function automatic logic [N-1:0] m_grant_vec();
      logic [N-1:0] v;
      v = '0;
      if (m_fire()) v[m_win] = 1'b1;
      return v;
   endfunction

   function automatic bit m_busy();
      bit b;
      b = (m_phase != 0);
      for (int i = 0; i < N; i++) if (m_kind[i] != 0) b = 1'b1;
      return b;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_active[i] = 1'b0;
         m_kind[i]   = 0;
      end
      m_phase = 0; m_win = 0; m_ptr = 0; m_cnt = 0;
      m_dir = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step();
      int p;
      if (rst) begin
         model_reset();
         return;
      end
      p = m_phase;
      if (m_fire()) begin
         m_active[m_win] = m_dir;
         m_cnt           = m_cnt + (m_dir ? 1 : -1);
         m_kind[m_win]   = 0;
      end
      if ((p == 2) && (int'(mon_count) != m_cnt)) m_err = 1'b1;
      if (p == 0) begin
         for (int k = 0; k < N; k++) begin
            int d;
            d = (m_ptr + k) % N;
            if (m_kind[d] != 0) begin
               m_win   = d;
               m_dir   = (m_kind[d] == 1);
               m_ptr   = (d + 1) % N;
               m_phase = 1;
               break;
            end
         end
      end else if (p == 1) begin
         m_phase = 2;
      end else begin
         m_phase = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (join_req[i] && !leave_req[i]) begin
            if (!m_active[i] && (m_kind[i] == 0)) m_kind[i] = 1;
         end else if (leave_req[i] && !join_req[i]) begin
            if (m_kind[i] == 1)   m_kind[i] = 0;
            else if (m_active[i]) m_kind[i] = 2;
         end
      end
   endtask

   // One clock: model advances with the DUT, then the bench sits at the
   // falling edge where outputs are sampled and inputs are driven.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      mon_count = bad_mon ? 8'h00 : 8'(m_cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1; join_req = '0; leave_req = '0;
      tick();
      rst = 1'b0;
   endtask

   // ---------------- Scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; join_req = 8'h01; leave_req = '0;
      tick(); tick();
      n_checks++;
      if ({change, on_off, grant} !== 10'd0) begin
         n_fail++; $display("FAIL reset_strobe got=%b exp=0", {change, on_off, grant});
      end
      n_checks++;
      if (active !== 8'h00) begin
         n_fail++; $display("FAIL reset_active got=%h exp=00", active);
      end
      n_checks++;
      if ({busy, sync_err} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags got=%b exp=00", {busy, sync_err});
      end
      rst = 1'b0;
      tick();
      join_req = '0;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_held_req_sampled busy got=%b exp=1", busy);
      end
      repeat (5) tick();
   endtask

   task automatic test_single_join();
      do_reset();
      join_req = 8'h01;
      tick();
      join_req = '0;
      n_checks++;
      if ({change, busy} !== 2'b01) begin
         n_fail++; $display("FAIL single_pending got=%b exp=01", {change, busy});
      end
      tick();
      n_checks++;
      if ({change, on_off, grant} !== {1'b1, 1'b1, 8'h01}) begin
         n_fail++; $display("FAIL single_issue got=%b exp=%b", {change, on_off, grant}, {1'b1, 1'b1, 8'h01});
      end
      tick();
      n_checks++;
      if ({change, active} !== {1'b0, 8'h01}) begin
         n_fail++; $display("FAIL single_settle got=%b/%h exp=0/01", change, active);
      end
      tick();
      n_checks++;
      if ({sync_err, busy} !== 2'b00) begin
         n_fail++; $display("FAIL single_done got=%b exp=00", {sync_err, busy});
      end
   endtask

   task automatic test_all_join();
      do_reset();
      join_req = 8'hFF;
      tick();
      join_req = '0;
      for (int k = 0; k < N; k++) begin
         int waited;
         logic [N-1:0] exp_g;
         waited = 0;
         exp_g  = 8'(1 << k);
         while (!change && waited < 10) begin
            tick();
            waited++;
         end
         n_checks++;
         if ({change, on_off, grant} !== {1'b1, 1'b1, exp_g}) begin
            n_fail++; $display("FAIL all_join_grant%0d got=%b/%h exp=1/%h", k, change, grant, exp_g);
         end
         n_checks++;
         if (waited != ((k == 0) ? 1 : 2)) begin
            n_fail++; $display("FAIL all_join_spacing%0d got=%0d exp=%0d", k, waited, (k == 0) ? 1 : 2);
         end
         tick();
      end
      tick();
      n_checks++;
      if ({active, sync_err, busy} !== {8'hFF, 2'b00}) begin
         n_fail++; $display("FAIL all_join_final got=%h/%b/%b exp=ff/0/0", active, sync_err, busy);
      end
   endtask

   task automatic test_ignored();
      bit saw;
      do_reset();
      join_req = 8'h04;
      tick();
      join_req = '0;
      repeat (5) tick();
      join_req = 8'h04;
      tick();
      join_req = '0;
      saw = 1'b0;
      repeat (6) begin
         if (change) saw = 1'b1;
         tick();
      end
      n_checks++;
      if ({saw, active} !== {1'b0, 8'h04}) begin
         n_fail++; $display("FAIL ignored_join got=%b/%h exp=0/04", saw, active);
      end
      leave_req = 8'h20;
      tick();
      leave_req = '0;
      saw = 1'b0;
      repeat (6) begin
         if (change) saw = 1'b1;
         tick();
      end
      n_checks++;
      if ({saw, active, busy} !== {1'b0, 8'h04, 1'b0}) begin
         n_fail++; $display("FAIL ignored_leave got=%b/%h/%b exp=0/04/0", saw, active, busy);
      end
   endtask

   task automatic test_conflict();
      bit saw;
      join_req = 8'h08; leave_req = 8'h08;
      tick();
      join_req = '0; leave_req = '0;
      saw = 1'b0;
      repeat (6) begin
         if (change) saw = 1'b1;
         tick();
      end
      n_checks++;
      if ({saw, busy} !== 2'b00) begin
         n_fail++; $display("FAIL conflict_same_cycle got=%b exp=00", {saw, busy});
      end
      join_req = 8'h08;
      tick();
      join_req = '0; leave_req = 8'h08;
      tick();
      leave_req = '0;
      saw = 1'b0;
      repeat (6) begin
         if (change) saw = 1'b1;
         tick();
      end
      n_checks++;
      if ({saw, active, busy} !== {1'b0, 8'h04, 1'b0}) begin
         n_fail++; $display("FAIL conflict_cancel got=%b/%h/%b exp=0/04/0", saw, active, busy);
      end
   endtask

   task automatic test_sync_err();
      bad_mon = 1'b1;
      do_reset();
      join_req = 8'h02;
      tick();
      join_req = '0;
      tick();
      n_checks++;
      if ({change, grant} !== {1'b1, 8'h02}) begin
         n_fail++; $display("FAIL sync_issue got=%b/%h exp=1/02", change, grant);
      end
      tick();
      n_checks++;
      if (sync_err !== 1'b0) begin
         n_fail++; $display("FAIL sync_early got=%b exp=0", sync_err);
      end
      tick();
      n_checks++;
      if (sync_err !== 1'b1) begin
         n_fail++; $display("FAIL sync_set got=%b exp=1", sync_err);
      end
      bad_mon = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (sync_err !== 1'b1) begin
         n_fail++; $display("FAIL sync_sticky got=%b exp=1", sync_err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (sync_err !== 1'b0) begin
         n_fail++; $display("FAIL sync_cleared got=%b exp=0", sync_err);
      end
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      join_req = 8'h11;
      tick();
      join_req = '0;
      tick();
      n_checks++;
      if ({change, grant} !== {1'b1, 8'h01}) begin
         n_fail++; $display("FAIL midrst_issue got=%b/%h exp=1/01", change, grant);
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if ({change, active, busy} !== {1'b0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL midrst_cleared got=%b/%h/%b exp=0/00/0", change, active, busy);
      end
      rst = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({change, active, busy} !== {1'b0, 8'h00, 1'b0}) begin
         n_fail++; $display("FAIL midrst_pending_lost got=%b/%h/%b exp=0/00/0", change, active, busy);
      end
   endtask

   task automatic test_random();
      logic [2*N+4:0] got, exp;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         join_req  = N'($urandom & $urandom & $urandom);
         leave_req = N'($urandom & $urandom & $urandom);
         rst       = ($urandom_range(0, 199) == 0);
         bad_mon   = ($urandom_range(0, 149) == 0);
         tick();
         got = {change, on_off, grant, active, busy, sync_err};
         exp = {m_fire(), m_fire() && m_dir, m_grant_vec(), m_active_vec(), m_busy(), m_err};
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_cycle%0d got=%b exp=%b", c, got, exp);
         end
      end
      rst = 1'b0; bad_mon = 1'b0; join_req = '0; leave_req = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; join_req = '0; leave_req = '0; mon_count = '0; bad_mon = 1'b0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_join();
      test_all_join();
      test_ignored();
      test_conflict();
      test_sync_err();
      test_reset_mid_issue();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
